// File: rtl/apb_ssd_ctrl_if.sv
// APB3 bus bundle for the seven-segment display controller.
// The responder takes the slave modport and the bus driver takes the master modport.
interface apb_ssd_ctrl_if;
  logic [2:0]  S_PADDR;
  logic        S_PWRITE;
  logic        S_PSELx;
  logic        S_PENABLE;
  logic [15:0] S_PWDATA;
  logic [15:0] S_PRDATA;
  logic        S_PREADY;
  logic        S_PSLVERR;

  modport slave (
    input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    output S_PRDATA, S_PREADY, S_PSLVERR
  );

  modport master (
    output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    input  S_PRDATA, S_PREADY, S_PSLVERR
  );
endinterface

// File: rtl/apb_ssd_ctrl.sv
// APB3-controlled six-digit hex seven-segment driver with per-digit enable and blink.
// Writes complete with zero wait states, reads with one wait state, and segment outputs are registered.
//
//   state     | meaning
//   ST_IDLE   | waiting for a setup phase (PSELx && !PENABLE)
//   ST_ACCESS | access phase: a write commits here, a read captures PRDATA
//   ST_WAIT   | read completion cycle, PREADY=1 with the captured data
module apb_ssd_ctrl #(
  parameter int          INVERT      = 1,
  parameter logic [15:0] BLINK_RESET = 16'd50000
) (
  input  logic          clk,
  input  logic          reset,
  apb_ssd_ctrl_if.slave s_apb,
  output logic [6:0]    ssd0,
  output logic [6:0]    ssd1,
  output logic [6:0]    ssd2,
  output logic [6:0]    ssd3,
  output logic [6:0]    ssd4,
  output logic [6:0]    ssd5
);
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT} state_t;

  localparam logic [6:0] SEG_ZERO = 7'b0111111;
  localparam logic [6:0] SSD_RST  = (INVERT != 0) ? ~SEG_ZERO : SEG_ZERO;

  state_t      r_state;
  logic [15:0] r_prdata;
  logic        r_pready;
  logic        r_pslverr;
  logic [23:0] r_dig;
  logic [5:0]  r_en;
  logic [5:0]  r_mask;
  logic [15:0] r_div;
  logic [15:0] r_presc;
  logic        r_phase;
  logic [6:0]  r_ssd [6];

  logic        w_bad_addr;
  logic        w_wr_en;
  logic        w_div_wr;
  logic [15:0] w_rd_mux;
  logic [6:0]  w_seg [6];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  assign w_bad_addr = (s_apb.S_PADDR >= 3'd5);
  assign w_wr_en    = (r_state == ST_ACCESS) && s_apb.S_PSELx && s_apb.S_PENABLE && s_apb.S_PWRITE;
  assign w_div_wr   = w_wr_en && (s_apb.S_PADDR == 3'd3);

  always_comb begin
    w_rd_mux = 16'h0000;
    case (s_apb.S_PADDR)
      3'd0: w_rd_mux = r_dig[15:0];
      3'd1: w_rd_mux = {8'h00, r_dig[23:16]};
      3'd2: w_rd_mux = {4'h0, r_mask, r_en};
      3'd3: w_rd_mux = r_div;
      3'd4: w_rd_mux = {15'h0000, r_phase};
      default: w_rd_mux = 16'h0000;
    endcase
  end

  // PREADY/PSLVERR for writes are launched on entry to ACCESS so they are high during that cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_prdata  <= 16'h0000;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_prdata  <= 16'h0000;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (s_apb.S_PSELx && !s_apb.S_PENABLE) begin
            r_state   <= ST_ACCESS;
            r_pready  <= s_apb.S_PWRITE;
            r_pslverr <= s_apb.S_PWRITE && w_bad_addr;
          end
        end
        ST_ACCESS: begin
          r_state <= ST_IDLE;
          if (s_apb.S_PSELx && s_apb.S_PENABLE && !s_apb.S_PWRITE) begin
            r_state   <= ST_WAIT;
            r_pready  <= 1'b1;
            r_pslverr <= w_bad_addr;
            r_prdata  <= w_rd_mux;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dig  <= 24'h000000;
      r_en   <= 6'h3F;
      r_mask <= 6'h00;
      r_div  <= BLINK_RESET;
    end else if (w_wr_en) begin
      case (s_apb.S_PADDR)
        3'd0: r_dig[15:0]  <= s_apb.S_PWDATA;
        3'd1: r_dig[23:16] <= s_apb.S_PWDATA[7:0];
        3'd2: begin
          r_en   <= s_apb.S_PWDATA[5:0];
          r_mask <= s_apb.S_PWDATA[11:6];
        end
        3'd3: r_div <= s_apb.S_PWDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || (r_div == 16'h0000) || w_div_wr) begin
      r_presc <= 16'h0000;
      r_phase <= 1'b0;
    end else if (r_presc == r_div) begin
      r_presc <= 16'h0000;
      r_phase <= ~r_phase;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      w_seg[i] = 7'h00;
      if (r_en[i] && !(r_mask[i] && r_phase)) w_seg[i] = seg7(r_dig[4*i +: 4]);
      if (INVERT != 0) w_seg[i] = ~w_seg[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (!reset) r_ssd[i] <= SSD_RST;
      else        r_ssd[i] <= w_seg[i];
    end
  end

  assign s_apb.S_PRDATA  = r_prdata;
  assign s_apb.S_PREADY  = r_pready;
  assign s_apb.S_PSLVERR = r_pslverr;
  assign ssd0 = r_ssd[0];
  assign ssd1 = r_ssd[1];
  assign ssd2 = r_ssd[2];
  assign ssd3 = r_ssd[3];
  assign ssd4 = r_ssd[4];
  assign ssd5 = r_ssd[5];
endmodule

// File: tb/tb_apb_ssd_ctrl.sv
// Directed bench for apb_ssd_ctrl: bus timing, register map, decode, blink, errors and reset.
module tb_apb_ssd_ctrl;
  logic       clk;
  logic       reset;
  logic [6:0] ssd0, ssd1, ssd2, ssd3, ssd4, ssd5;
  int         n_checks;
  int         n_fail;
  logic [15:0] rd;
  logic        err;
  logic [6:0]  exp0;

  localparam logic [6:0] S_BLANK = 7'h7F;
  localparam logic [6:0] S_ZERO  = 7'b1000000;
  localparam logic [6:0] S_ONE   = 7'b1111001;
  localparam logic [6:0] S_TWO   = 7'b0100100;
  localparam logic [6:0] S_F     = 7'b0001110;
  localparam logic [6:0] S_EIGHT = 7'b0000000;

  apb_ssd_ctrl_if bus ();

  apb_ssd_ctrl #(.INVERT(1), .BLINK_RESET(16'd50000)) dut (
    .clk(clk), .reset(reset), .s_apb(bus),
    .ssd0(ssd0), .ssd1(ssd1), .ssd2(ssd2), .ssd3(ssd3), .ssd4(ssd4), .ssd5(ssd5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [15:0] d, input logic exp_err);
    bus.S_PSELx = 1'b1; bus.S_PENABLE = 1'b0; bus.S_PWRITE = 1'b1;
    bus.S_PADDR = a;    bus.S_PWDATA = d;
    tick();
    chk("wr_pready_access", bus.S_PREADY, 1);
    chk("wr_pslverr", bus.S_PSLVERR, exp_err);
    bus.S_PENABLE = 1'b1;
    tick();
    bus.S_PSELx = 1'b0; bus.S_PENABLE = 1'b0; bus.S_PWRITE = 1'b0;
    chk("wr_pready_after", bus.S_PREADY, 0);
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [15:0] d, output logic e);
    bus.S_PSELx = 1'b1; bus.S_PENABLE = 1'b0; bus.S_PWRITE = 1'b0; bus.S_PADDR = a;
    tick();
    chk("rd_pready_access", bus.S_PREADY, 0);
    bus.S_PENABLE = 1'b1;
    tick();
    chk("rd_pready_wait", bus.S_PREADY, 1);
    d = bus.S_PRDATA;
    e = bus.S_PSLVERR;
    tick();
    bus.S_PSELx = 1'b0; bus.S_PENABLE = 1'b0;
    chk("rd_pready_after", bus.S_PREADY, 0);
    chk("rd_prdata_after", bus.S_PRDATA, 0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    bus.S_PSELx = 1'b0; bus.S_PENABLE = 1'b0; bus.S_PWRITE = 1'b0;
    bus.S_PADDR = 3'd0; bus.S_PWDATA = 16'h0000;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;

    chk("rst_ssd0", ssd0, S_ZERO); chk("rst_ssd1", ssd1, S_ZERO);
    chk("rst_ssd2", ssd2, S_ZERO); chk("rst_ssd3", ssd3, S_ZERO);
    chk("rst_ssd4", ssd4, S_ZERO); chk("rst_ssd5", ssd5, S_ZERO);
    chk("rst_pready", bus.S_PREADY, 0);
    chk("rst_pslverr", bus.S_PSLVERR, 0);
    chk("rst_prdata", bus.S_PRDATA, 0);
    apb_read(3'd4, rd, err); chk("rst_status", rd, 16'h0000); chk("rst_status_err", err, 0);
    apb_read(3'd2, rd, err); chk("rst_ctrl", rd, 16'h003F);
    apb_read(3'd3, rd, err); chk("rst_div", rd, 16'd50000);

    apb_write(3'd0, 16'h8F21, 1'b0);
    chk("dec_ssd0_latency", ssd0, S_ZERO);
    tick();
    chk("dec_ssd0", ssd0, S_ONE); chk("dec_ssd1", ssd1, S_TWO);
    chk("dec_ssd2", ssd2, S_F);   chk("dec_ssd3", ssd3, S_EIGHT);
    chk("dec_ssd4", ssd4, S_ZERO);

    apb_write(3'd2, 16'h003E, 1'b0);
    tick();
    chk("en_ssd0_blank", ssd0, S_BLANK);
    chk("en_ssd1_on", ssd1, S_TWO);

    apb_write(3'd2, 16'h007F, 1'b0);
    apb_write(3'd3, 16'd3, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp0 = ((((k - 1) / 4) % 2) == 1) ? S_BLANK : S_ONE;
      chk($sformatf("blink_ssd0_c%0d", k), ssd0, exp0);
      chk($sformatf("blink_ssd1_c%0d", k), ssd1, S_TWO);
    end

    apb_write(3'd3, 16'd0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("noblink_ssd0_c%0d", k), ssd0, S_ONE);
    end
    apb_read(3'd4, rd, err); chk("noblink_status", rd, 16'h0000);

    apb_write(3'd6, 16'hFFFF, 1'b1);
    apb_read(3'd0, rd, err); chk("err_diglo", rd, 16'h8F21); chk("err_diglo_ok", err, 0);
    apb_read(3'd1, rd, err); chk("err_dighi", rd, 16'h0000);
    apb_read(3'd2, rd, err); chk("err_ctrl", rd, 16'h007F);
    apb_read(3'd3, rd, err); chk("err_div", rd, 16'h0000);
    apb_read(3'd5, rd, err); chk("err_rd5_data", rd, 16'h0000); chk("err_rd5_slverr", err, 1);

    bus.S_PSELx = 1'b1; bus.S_PENABLE = 1'b0; bus.S_PWRITE = 1'b1;
    bus.S_PADDR = 3'd1; bus.S_PWDATA = 16'h0034;
    tick();
    bus.S_PSELx = 1'b0; bus.S_PWRITE = 1'b0;
    tick(); tick();
    apb_read(3'd1, rd, err); chk("abandon_dighi", rd, 16'h0000);
    chk("abandon_ssd4", ssd4, S_ZERO);

    bus.S_PSELx = 1'b1; bus.S_PENABLE = 1'b0; bus.S_PWRITE = 1'b1;
    bus.S_PADDR = 3'd1; bus.S_PWDATA = 16'h00AB;
    tick();
    bus.S_PENABLE = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.S_PSELx = 1'b0; bus.S_PENABLE = 1'b0; bus.S_PWRITE = 1'b0;
    chk("midrst_pready", bus.S_PREADY, 0);
    tick();
    apb_read(3'd1, rd, err); chk("midrst_dighi", rd, 16'h0000);
    apb_read(3'd2, rd, err); chk("midrst_ctrl", rd, 16'h003F);
    chk("midrst_ssd4", ssd4, S_ZERO);
    chk("midrst_ssd5", ssd5, S_ZERO);
    chk("midrst_ssd0", ssd0, S_ZERO);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_ssd_ctrl.md
APB_SSD_CTRL -- requirements
Module: apb_ssd_ctrl

Interface
REQ-001 SHALL have parameter INVERT, default 1; 1 drives segment outputs active-low, 0 drives them active-high.
REQ-002 SHALL have parameter BLINK_RESET, default 16'd50000; this is the reset value of BLINK_DIV.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit; synchronous, active-low.
REQ-005 SHALL have port S_PADDR, input, 3 bits; APB word address.
REQ-006 SHALL have port S_PWRITE, input, 1 bit; APB write strobe.
REQ-007 SHALL have port S_PSELx, input, 1 bit; APB select.
REQ-008 SHALL have port S_PENABLE, input, 1 bit; APB access phase.
REQ-009 SHALL have port S_PWDATA, input, 16 bits; APB write data.
REQ-010 SHALL have port S_PRDATA, output, 16 bits; APB read data.
REQ-011 SHALL have port S_PREADY, output, 1 bit; APB ready.
REQ-012 SHALL have port S_PSLVERR, output, 1 bit; APB error.
REQ-013 SHALL have ports ssd0..ssd5, output, 7 bits each; segments, bit0=a through bit6=g.

Function
REQ-014 SHALL implement an APB3 responder with a three-state FSM: IDLE, ACCESS, WAIT.
- IDLE: on PSELx and !PENABLE -> ACCESS.
- ACCESS, write: PREADY=1 this cycle; register updated at this edge; -> IDLE.
- ACCESS, read: PREADY=0; PRDATA captured; -> WAIT.
- WAIT: PREADY=1 with the captured PRDATA; -> IDLE.
REQ-015 SHALL therefore complete writes with 0 wait states and reads with exactly 1 wait state.
REQ-016 SHALL drive PREADY=0 and PRDATA=0 outside completing cycles.
REQ-017 SHALL use the following register map; unused bits read 0, and writes to them are ignored.
- 0 DIG_LO: digits 0..3, 4 bits each, digit0 in [3:0].
- 1 DIG_HI: digits 4..5 in [7:0].
- 2 CTRL: [5:0] digit enable; [11:6] blink mask.
- 3 BLINK_DIV: [15:0].
- 4 STATUS, read-only: [0] blink phase; writes ignored.
REQ-018 SHALL, for addresses 5..7, assert PSLVERR together with PREADY in the completing cycle, read 0, and leave all registers unchanged.
REQ-019 SHALL deassert PSELx-abandoned transfers: if PSELx drops while in ACCESS or WAIT, the FSM returns to IDLE with no register write.
REQ-020 SHALL run a 16-bit prescaler that increments each cycle; when it equals BLINK_DIV it clears to 0 and the blink phase toggles.
REQ-021 SHALL, when BLINK_DIV=0, hold the prescaler and phase at 0, which disables blinking.
REQ-022 SHALL, on any write to BLINK_DIV, clear the prescaler and phase in the same edge.
REQ-023 SHALL show digit i when enable[i] && !(mask[i] && phase); otherwise digit i SHALL be blank.
REQ-024 SHALL decode shown digits as hex 0-F using the team's standard 7-segment table (e.g. 0=7'b0111111, 8=7'b1111111, F=7'b1110001, active-high).
REQ-025 SHALL define blank as all segments off.
REQ-026 SHALL invert all segment outputs when INVERT=1.
REQ-027 SHALL register the segment outputs, so any register write or phase change is visible exactly 1 cycle after the edge that caused it.

Reset
REQ-028 SHALL apply the following on reset=0 at a rising edge:
- digits=0, enable=6'h3F, mask=0, BLINK_DIV=BLINK_RESET.
- prescaler=0, phase=0, FSM=IDLE.
- PRDATA=0, PREADY=0, PSLVERR=0.
- ssd0..5=7'b1000000 (INVERT=1).
REQ-029 SHALL abort any transfer in progress when reset is asserted mid-transfer; no register is written and the FSM is in IDLE after the edge.

Verification
REQ-030 The bench SHALL cover reset: hold reset=0 for 2 cycles, then release -> all ssd=7'b1000000, STATUS reads 0, CTRL reads 16'h003F.
REQ-031 The bench SHALL cover write decode: write DIG_LO=16'h8F21 -> next cycle ssd0=~'1'=7'b1111001, ssd1=~'2'=7'b0100100, ssd2=~'F'=7'b0001110, ssd3=~'8'=7'b0000000; write takes 2 bus cycles.
REQ-032 The bench SHALL cover read timing: read CTRL after reset -> PREADY low in ACCESS, high in the next cycle with PRDATA=16'h003F; the read takes 3 bus cycles total.
REQ-033 The bench SHALL cover blink: set BLINK_DIV=3, CTRL=16'h007F (mask bit0) -> ssd0 toggles between the digit and 7'h7F every 4 cycles, other digits steady; BLINK_DIV=0 -> ssd0 steady on.
REQ-034 The bench SHALL cover error: write address 6 with 16'hFFFF -> PSLVERR=1 with PREADY, all registers unchanged; read address 5 -> PRDATA=0, PSLVERR=1.
REQ-035 The bench SHALL cover reset mid-transfer: assert reset during the ACCESS cycle of a DIG_HI write of 16'h00AB -> DIG_HI reads 0 after reset, and ssd4=ssd5=7'b1000000.
